spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Command decoder for the FPGA SPI slave path. It sits directly downstream of the SPI slave byte receiver: it consumes each received MOSI byte together with the chip-select framing, and parses each frame as a one-byte command followed by data bytes. It executes register writes into a small local register file and presents the byte the slave shifts out on MISO during the next byte slot.

## Interface
- `REG_COUNT`, default 16: number of 8-bit registers; must be a power of two, 2..16. Address width `AW` = log2(`REG_COUNT`).
- `clk`, in, 1: system clock; every register in the block is clocked on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `cs_active`, in, 1: frame-active level from the slave. 1 means selected, the same polarity as the slave's `spi_cs`.
- `rx_valid`, in, 1: one-cycle pulse; a complete byte is on `rx_data`.
- `rx_data`, in, 8: received MOSI byte.
- `tx_data`, out, 8: byte the slave loads for the next MISO slot.
- `tx_load`, out, 1: one-cycle pulse; `tx_data` was updated this cycle.
- `reg_wr_en`, out, 1: one-cycle write strobe to the fabric.
- `reg_wr_addr`, out, `AW`: write address.
- `reg_wr_data`, out, 8: write data.
- `reg_out`, out, 8*`REG_COUNT`: flattened register file; register i occupies bits [8i+7:8i].
- `err`, out, 1: frame error flag.

## Operation
- Command byte format:
  - bit7: 1 = write, 0 = read.
  - bits6:4 must be 000.
  - bits[AW-1:0] hold the address.
  - Bits 3:AW are ignored.
- States:
  - IDLE: `cs_active`=0.
  - CMD: waiting for the command byte.
  - WR: waiting for data bytes of a write.
  - RD: serving read slots.
  - DONE: surplus bytes are ignored.
  - ERR: bad command.
- Transitions:
  - IDLE→CMD when `cs_active`=1.
  - From any state: `cs_active`=0 → IDLE on the next edge. The frame ends and any partial operation is abandoned.
  - CMD on `rx_valid`:
    - bits6:4≠0 → ERR, and `err` is set.
    - Write command → WR; the address is latched.
    - Read command → RD; `tx_data` is loaded with reg[addr] and `tx_load` pulses.
  - WR on `rx_valid`: reg[addr] is written with `rx_data`, `reg_wr_en` pulses with the address and data, and the state moves to DONE (see Configuration).
  - RD on `rx_valid` (dummy byte): `tx_data` is loaded with 0x00, `tx_load` pulses, and the state moves to DONE (see Configuration).
  - DONE and ERR: `rx_valid` is ignored. No writes occur; `tx_data` is held.
- `err` stays set until the next IDLE→CMD transition, which clears it.
- `rx_valid` with `cs_active`=0 is ignored entirely. If both occur in the same cycle, chip-select deassertion wins.
- Registers are only written through MOSI. Reads never modify state.

## Timing
- All outputs are registered. Latency from the `rx_valid` cycle to `reg_wr_en` or `tx_load` is 1 cycle.
- The register file updates on the same edge that `reg_wr_en` asserts. A read command in the very next frame sees the new value.
- Reset values:
  - state IDLE.
  - `tx_data`=0x00, `tx_load`=0.
  - `reg_wr_en`=0, `reg_wr_addr`=0, `reg_wr_data`=0.
  - `err`=0.
  - all registers 0x00.
- Reset mid-frame: the state returns to IDLE. If `cs_active` is still 1 after reset, the block enters CMD and the next byte is treated as a command.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no lost bytes.

## Configuration
- `SPI_CMD_AUTOINC_EN` defined, burst mode:
  - WR stays in WR. Each further data byte writes addr+1, addr+2, ….
  - RD stays in RD. Each dummy byte loads reg[next addr].
  - Addresses wrap modulo `REG_COUNT`, e.g. 15→0 at `REG_COUNT`=16.
- Not defined: single-byte transfers exactly as described in Operation; surplus bytes go to DONE.

## Structure
- Package `spi_cmd_pkg` holds:
  - the state encoding constants (IDLE, CMD, WR, RD, DONE, ERR);
  - `CMD_WRITE_BIT`=7;
  - the reserved-field mask 0x70;
  - `DATA_W`=8.
- One sub-module, `spi_cmd_regfile`: `REG_COUNT`×8 storage with a synchronous write port and an asynchronous read mux, plus the flattened `reg_out`. The FSM and output registers live in `spi_cmd_decoder`.

## Test plan
- Write: frame 0x83, 0x5A → one cycle after the second `rx_valid`, `reg_wr_en`=1 for exactly one cycle with `reg_wr_addr`=3 and `reg_wr_data`=0x5A; afterwards `reg_out[31:24]`=0x5A.
- Read after write: new frame 0x03, dummy 0x00 → one cycle after the first `rx_valid`, `tx_load` pulses with `tx_data`=0x5A. After the dummy byte, `tx_data`=0x00 without the macro.
- Bad command: frame 0x93, 0x77 → `err`=1 one cycle after the first byte, no `reg_wr_en`, and all registers unchanged. `err` returns to 0 one cycle after the next frame's `cs_active` rise.
- Burst wrap with `SPI_CMD_AUTOINC_EN`: frame 0x8F, 0x11, 0x22 sent back-to-back → reg15=0x11, reg0=0x22. Without the macro, reg15=0x11 and reg0 stays 0x00.
- Abandoned frame: 0x85, then `cs_active` drops before any data; the next frame sends 0x02 → no write occurs, and 0x02 is decoded as a read command (`tx_data`=reg2).
- Reset mid-frame: assert `rst_n`=0 during WR after 0x84 → all outputs and registers read 0. Then, with `cs_active` held at 1, the byte 0x04 is decoded as a read command.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM state encoding,
// command-byte field positions and the data width.
package spi_cmd_pkg;

    localparam int DATA_W        = 8;
    localparam int CMD_WRITE_BIT = 7;
    localparam logic [DATA_W-1:0] CMD_RSVD_MASK = 8'h70;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // A command is malformed when any reserved bit (6:4) is set.
    function automatic logic cmd_is_bad(input logic [DATA_W-1:0] cmd);
        return |(cmd & CMD_RSVD_MASK);
    endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// REG_COUNT x 8 register file: one synchronous write port, one asynchronous
// read port, and the whole array exposed as a flat bus.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter  int REG_COUNT = 16,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wr_en,
    input  logic [AW-1:0]               i_wr_addr,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic [AW-1:0]               i_rd_addr,
    output logic [DATA_W-1:0]           o_rd_data,
    output logic [DATA_W*REG_COUNT-1:0] o_reg_out
);

    logic [DATA_W-1:0] r_mem [REG_COUNT];

    // NOTE: non-blocking assignments for all clocked state so every flop
    // samples pre-edge values regardless of process ordering.
    // NOTE: the array is reset because reg_out is visible to the fabric and
    // must read as all-zero after reset, not as power-up garbage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign o_reg_out[DATA_W*g +: DATA_W] = r_mem[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI slave command decoder: parses <cmd><data...> frames, writes the local
// register file and supplies MISO bytes. Define SPI_CMD_AUTOINC_EN for burst mode.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter  int REG_COUNT = 16,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs_active,
    input  logic                        rx_valid,
    input  logic [DATA_W-1:0]           rx_data,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_load,
    output logic                        reg_wr_en,
    output logic [AW-1:0]               reg_wr_addr,
    output logic [DATA_W-1:0]           reg_wr_data,
    output logic [DATA_W*REG_COUNT-1:0] reg_out,
    output logic                        err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     w_addr_nxt;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_load;
    logic              r_reg_wr_en;
    logic [AW-1:0]     r_reg_wr_addr;
    logic [DATA_W-1:0] r_reg_wr_data;
    logic              r_err;

    logic [DATA_W-1:0] w_tx_data_nxt;
    logic              w_tx_load;
    logic              w_wr_en;
    logic              w_err_nxt;

`ifdef SPI_CMD_AUTOINC_EN
    logic [AW-1:0] w_addr_inc;
    assign w_addr_inc = r_addr + AW'(1);
    // In a read burst the next MISO byte comes from the following address.
    assign w_rd_addr  = (r_state == ST_RD) ? w_addr_inc : rx_data[AW-1:0];
`else
    assign w_rd_addr  = rx_data[AW-1:0];
`endif

    // The write lands in the array on the same edge that reg_wr_en rises.
    spi_cmd_regfile #(
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_addr),
        .i_wr_data (rx_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .o_reg_out (reg_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_tx_data_nxt = r_tx_data;
        w_tx_load     = 1'b0;
        w_wr_en       = 1'b0;
        w_err_nxt     = r_err;

        if (!cs_active) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_CMD;
                    w_err_nxt   = 1'b0;
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        if (cmd_is_bad(rx_data)) begin
                            w_state_nxt = ST_ERR;
                            w_err_nxt   = 1'b1;
                        end else if (rx_data[CMD_WRITE_BIT]) begin
                            w_state_nxt = ST_WR;
                            w_addr_nxt  = rx_data[AW-1:0];
                        end else begin
                            w_state_nxt   = ST_RD;
                            w_addr_nxt    = rx_data[AW-1:0];
                            w_tx_load     = 1'b1;
                            w_tx_data_nxt = w_rd_data;
                        end
                    end
                end
                ST_WR: begin
                    if (rx_valid) begin
                        w_wr_en = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                        w_addr_nxt  = w_addr_inc;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
                ST_RD: begin
                    if (rx_valid) begin
                        w_tx_load = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                        w_addr_nxt    = w_addr_inc;
                        w_tx_data_nxt = w_rd_data;
`else
                        w_tx_data_nxt = '0;
                        w_state_nxt   = ST_DONE;
`endif
                    end
                end
                default: begin
                    // DONE and ERR sit out the rest of the frame.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_data     <= '0;
            r_tx_load     <= 1'b0;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_addr <= '0;
            r_reg_wr_data <= '0;
            r_err         <= 1'b0;
        end else begin
            r_tx_data   <= w_tx_data_nxt;
            r_tx_load   <= w_tx_load;
            r_reg_wr_en <= w_wr_en;
            r_err       <= w_err_nxt;
            if (w_wr_en) begin
                r_reg_wr_addr <= r_addr;
                r_reg_wr_data <= rx_data;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_load     = r_tx_load;
    assign reg_wr_en   = r_reg_wr_en;
    assign reg_wr_addr = r_reg_wr_addr;
    assign reg_wr_data = r_reg_wr_data;
    assign err         = r_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (REG_COUNT = 16).
// Expectations follow SPI_CMD_AUTOINC_EN when the bench is built with it.
module tb_spi_cmd_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cs_active;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic [7:0]   tx_data;
    logic         tx_load;
    logic         reg_wr_en;
    logic [3:0]   reg_wr_addr;
    logic [7:0]   reg_wr_data;
    logic [127:0] reg_out;
    logic         err;

    logic [127:0] exp_regs;
    int n_pass  = 0;
    int n_total = 0;

    spi_cmd_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_active   (cs_active),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_out     (reg_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic frame_start();
        cs_active = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        cs_active = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        n_total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else n_pass++;
        n_total++; if (tx_load !== 1'b0) $display("FAIL rst_tx_load: got %b want 0", tx_load); else n_pass++;
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", reg_wr_en); else n_pass++;
        n_total++; if ({reg_wr_addr, reg_wr_data} !== 12'h000) $display("FAIL rst_wr_addr_data: got %h want 000", {reg_wr_addr, reg_wr_data}); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_total++; if (reg_out !== 128'h0) $display("FAIL rst_regs: got %h want 0", reg_out); else n_pass++;
        rst_n = 1'b1;
        tick();
        exp_regs = '0;
    endtask

    task automatic test_write();
        frame_start();
        send_byte(8'h83);
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL wr_cmd_no_strobe: got %b want 0", reg_wr_en); else n_pass++;
        send_byte(8'h5A);
        exp_regs[31:24] = 8'h5A;
        n_total++; if (reg_wr_en !== 1'b1) $display("FAIL wr_strobe: got %b want 1", reg_wr_en); else n_pass++;
        n_total++; if (reg_wr_addr !== 4'd3) $display("FAIL wr_addr: got %0d want 3", reg_wr_addr); else n_pass++;
        n_total++; if (reg_wr_data !== 8'h5A) $display("FAIL wr_data: got %h want 5a", reg_wr_data); else n_pass++;
        n_total++; if (reg_out !== exp_regs) $display("FAIL wr_regfile: got %h want %h", reg_out, exp_regs); else n_pass++;
        tick();
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL wr_strobe_width: got %b want 0", reg_wr_en); else n_pass++;
        frame_end();
    endtask

    task automatic test_read();
        frame_start();
        send_byte(8'h03);
        n_total++; if (tx_load !== 1'b1) $display("FAIL rd_load: got %b want 1", tx_load); else n_pass++;
        n_total++; if (tx_data !== 8'h5A) $display("FAIL rd_data: got %h want 5a", tx_data); else n_pass++;
        tick();
        n_total++; if (tx_load !== 1'b0) $display("FAIL rd_load_width: got %b want 0", tx_load); else n_pass++;
        n_total++; if (tx_data !== 8'h5A) $display("FAIL rd_data_hold: got %h want 5a", tx_data); else n_pass++;
        send_byte(8'h00);
        // Without burst mode the dummy slot returns 0x00; with it, reg4 (still 0x00).
        n_total++; if (tx_load !== 1'b1) $display("FAIL rd_dummy_load: got %b want 1", tx_load); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL rd_dummy_data: got %h want 00", tx_data); else n_pass++;
        n_total++; if (reg_out !== exp_regs) $display("FAIL rd_no_side_effect: got %h want %h", reg_out, exp_regs); else n_pass++;
        frame_end();
    endtask

    task automatic test_bad_cmd();
        frame_start();
        send_byte(8'h93);
        n_total++; if (err !== 1'b1) $display("FAIL bad_err_set: got %b want 1", err); else n_pass++;
        send_byte(8'h77);
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL bad_no_write: got %b want 0", reg_wr_en); else n_pass++;
        n_total++; if (reg_out !== exp_regs) $display("FAIL bad_regs: got %h want %h", reg_out, exp_regs); else n_pass++;
        frame_end();
        n_total++; if (err !== 1'b1) $display("FAIL bad_err_sticky: got %b want 1", err); else n_pass++;
        frame_start();
        n_total++; if (err !== 1'b0) $display("FAIL bad_err_clear: got %b want 0", err); else n_pass++;
        frame_end();
    endtask

    task automatic test_back_to_back();
        frame_start();
        rx_valid = 1'b1;
        rx_data  = 8'h8F;
        tick();
        rx_data  = 8'h11;
        tick();
        exp_regs[127:120] = 8'h11;
        n_total++; if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 4'hF, 8'h11}) $display("FAIL b2b_first: got %h want 1f11", {reg_wr_en, reg_wr_addr, reg_wr_data}); else n_pass++;
        rx_data  = 8'h22;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`ifdef SPI_CMD_AUTOINC_EN
        exp_regs[7:0] = 8'h22;
        n_total++; if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 4'h0, 8'h22}) $display("FAIL b2b_second: got %h want 1022", {reg_wr_en, reg_wr_addr, reg_wr_data}); else n_pass++;
`else
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL b2b_surplus_ignored: got %b want 0", reg_wr_en); else n_pass++;
`endif
        n_total++; if (reg_out !== exp_regs) $display("FAIL b2b_regs: got %h want %h", reg_out, exp_regs); else n_pass++;
        frame_end();
    endtask

    task automatic test_abandon();
        frame_start();
        send_byte(8'h82);
        send_byte(8'hC3);
        exp_regs[23:16] = 8'hC3;
        frame_end();
        frame_start();
        send_byte(8'h85);
        frame_end();
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL abandon_no_write: got %b want 0", reg_wr_en); else n_pass++;
        frame_start();
        send_byte(8'h02);
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL abandon_cmd_not_data: got %b want 0", reg_wr_en); else n_pass++;
        n_total++; if ({tx_load, tx_data} !== {1'b1, 8'hC3}) $display("FAIL abandon_read: got %h want 1c3", {tx_load, tx_data}); else n_pass++;
        n_total++; if (reg_out !== exp_regs) $display("FAIL abandon_regs: got %h want %h", reg_out, exp_regs); else n_pass++;
        frame_end();
    endtask

    task automatic test_reset_mid_frame();
        frame_start();
        send_byte(8'h84);
        rst_n = 1'b0;
        tick();
        exp_regs = '0;
        n_total++; if ({tx_data, tx_load, reg_wr_en, reg_wr_addr, reg_wr_data, err} !== 23'h0) $display("FAIL midrst_outputs: got %h want 0", {tx_data, tx_load, reg_wr_en, reg_wr_addr, reg_wr_data, err}); else n_pass++;
        n_total++; if (reg_out !== exp_regs) $display("FAIL midrst_regs: got %h want 0", reg_out); else n_pass++;
        rst_n = 1'b1;
        tick();
        send_byte(8'h04);
        n_total++; if (reg_wr_en !== 1'b0) $display("FAIL midrst_no_write: got %b want 0", reg_wr_en); else n_pass++;
        n_total++; if ({tx_load, tx_data} !== {1'b1, 8'h00}) $display("FAIL midrst_read: got %h want 100", {tx_load, tx_data}); else n_pass++;
        frame_end();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_back_to_back();
        test_abandon();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
